cpu_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 22 ++
 rtl/cpu_sequencer.sv | 128 ++++++++++++
 tb/tb_cpu_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the instruction sequencer: the 3-bit FSM state
// encodings, the opcode that stops sequencing, and the opcode whose
// instructions do not write the register file.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] HALT_OPCODE = 4'hF;
    localparam logic [3:0] NOWB_OPCODE = 4'b1001;

    localparam int INSTR_W  = 16;
    localparam int RETIRE_W = 16;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle instruction sequencer: fetches a 16-bit word from instruction
// memory, then steps it through DECODE, EXECUTE and WRITEBACK, counting
// retired instructions. A HALT opcode parks the sequencer until reset.
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   run              level; 1 permits fetching new instructions
//   imem_req         instruction-memory read request (FETCH only)
//   imem_addr        fetch address (= pc)
//   imem_ack         memory accepts request; imem_rdata valid same cycle
//   imem_rdata       fetched instruction word
//   ir               instruction register, feeds the external decoder
//   dec_write_enable write-enable decoded from ir
//   alu_en           execute strobe (EXECUTE only)
//   rf_we            register-file write strobe (WRITEBACK only)
//   pc               program counter
//   busy             high except in IDLE and HALT
//   halted           high in HALT
//   retired          saturating count of completed instructions
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [3:0]      HALT_OP  = HALT_OPCODE,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  ir,
    input  logic                dec_write_enable,
    output logic                alu_en,
    output logic                rf_we,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [INSTR_W-1:0]    r_ir;
    logic [PC_W-1:0]       r_pc;
    logic [RETIRE_W-1:0]   r_retired;
    logic                  w_fetch_done;

    function automatic logic [RETIRE_W-1:0] sat_inc(input logic [RETIRE_W-1:0] v);
        if (v == {RETIRE_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Acks are only honoured while a request is outstanding.
    assign w_fetch_done = (r_state == ST_FETCH) && imem_ack;

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:      if (run) w_state_nxt = ST_FETCH;
            ST_FETCH:     if (imem_ack) w_state_nxt = ST_DECODE;
            ST_DECODE:    w_state_nxt = (r_ir[15:12] == HALT_OP) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   w_state_nxt = ST_WRITEBACK;
            // run is only consulted between instructions, so dropping it
            // never aborts one already in flight.
            ST_WRITEBACK: w_state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT:      w_state_nxt = ST_HALT;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // ---- outputs ----
    always_comb begin
        imem_req = 1'b0;
        alu_en   = 1'b0;
        rf_we    = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        unique case (r_state)
            ST_IDLE:      ;
            ST_FETCH:     begin imem_req = 1'b1; busy = 1'b1; end
            ST_DECODE:    busy = 1'b1;
            ST_EXECUTE:   begin alu_en = 1'b1; busy = 1'b1; end
            ST_WRITEBACK: begin rf_we = dec_write_enable; busy = 1'b1; end
            ST_HALT:      halted = 1'b1;
            default:      ;
        endcase
    end

    // ---- PC / IR / retired counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            if (w_fetch_done) begin
                r_ir <= imem_rdata;
                r_pc <= r_pc + 1'b1;
            end
            if (r_state == ST_WRITEBACK) begin
                r_retired <= sat_inc(r_retired);
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    localparam int         PC_W     = 8;
    localparam logic [7:0] RESET_PC = 8'hFD;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        dec_write_enable;
    logic        alu_en;
    logic        rf_we;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    int n_vec;
    int n_err;

    cpu_sequencer #(
        .PC_W    (PC_W),
        .HALT_OP (4'hF),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .ir              (ir),
        .dec_write_enable(dec_write_enable),
        .alu_en          (alu_en),
        .rf_we           (rf_we),
        .pc              (pc),
        .busy            (busy),
        .halted          (halted),
        .retired         (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an instruction is either waiting to be fetched,
    // being fetched, or "age" cycles past the accepting ack (1..3).
    localparam int M_IDLE = 0, M_FETCH = 1, M_FLIGHT = 2, M_HALT = 3;
    int          m_mode;
    int          m_age;
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_ret;
    logic        m_valid = 1'b0;

    // The external decoder: opcode 1001 does not write back.
    assign dec_write_enable = (m_ir[15:12] != 4'b1001);

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_mode  <= M_IDLE;
            m_age   <= 0;
            m_pc    <= RESET_PC;
            m_ir    <= 16'h0;
            m_ret   <= 16'h0;
        end else if (m_valid) begin
            if (m_mode == M_IDLE) begin
                if (run) m_mode <= M_FETCH;
            end else if (m_mode == M_FETCH) begin
                if (imem_ack) begin
                    m_ir   <= imem_rdata;
                    m_pc   <= 8'((int'(m_pc) + 1) % 256);
                    m_mode <= M_FLIGHT;
                    m_age  <= 1;
                end
            end else if (m_mode == M_FLIGHT) begin
                if (m_age == 1 && m_ir[15:12] == 4'hF) begin
                    m_mode <= M_HALT;
                end else if (m_age < 3) begin
                    m_age <= m_age + 1;
                end else begin
                    if (m_ret != 16'hFFFF) m_ret <= m_ret + 16'd1;
                    m_mode <= run ? M_FETCH : M_IDLE;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("imem_req", 32'(imem_req), 32'(m_mode == M_FETCH));
            if (m_mode == M_FETCH) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("pc", 32'(pc), 32'(m_pc));
            chk("ir", 32'(ir), 32'(m_ir));
            chk("alu_en", 32'(alu_en), 32'(m_mode == M_FLIGHT && m_age == 2));
            chk("rf_we", 32'(rf_we),
                32'(m_mode == M_FLIGHT && m_age == 3 && m_ir[15:12] != 4'b1001));
            chk("busy", 32'(busy), 32'(m_mode == M_FETCH || m_mode == M_FLIGHT));
            chk("halted", 32'(halted), 32'(m_mode == M_HALT));
            chk("retired", 32'(retired), 32'(m_ret));
        end
    end

    // Apply current inputs across one rising edge, return at the falling edge.
    task automatic edge1();
        @(posedge clk);
        @(negedge clk);
    endtask

    int halt_cnt;

    initial begin
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
        n_vec = 0; n_err = 0;
        @(negedge clk);
        edge1(); edge1();
        chk("rst_pc", 32'(pc), 32'h0FD);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_ret", 32'(retired), 32'h0);
        chk("rst_flags", {28'h0, imem_req, busy, halted, alu_en}, 32'h0);

        // Single instruction, ack with the request.
        rst = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1250;
        edge1();
        chk("d1_fetch_req", 32'(imem_req), 32'h1);
        chk("d1_fetch_addr", 32'(imem_addr), 32'h0FD);
        edge1();
        chk("d1_ir", 32'(ir), 32'h1250);
        chk("d1_pc", 32'(pc), 32'h0FE);
        edge1();
        chk("d1_alu", 32'(alu_en), 32'h1);
        chk("d1_we_early", 32'(rf_we), 32'h0);
        edge1();
        chk("d1_rf_we", 32'(rf_we), 32'h1);
        run = 1'b0;
        edge1();
        chk("d1_retired", 32'(retired), 32'h1);
        chk("d1_idle", {30'h0, busy, rf_we}, 32'h0);

        // No-writeback opcode with ack delayed three cycles.
        run = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h9ABC;
        edge1();
        for (int i = 0; i < 3; i++) begin
            chk("d2_req_held", 32'(imem_req), 32'h1);
            chk("d2_addr_stable", 32'(imem_addr), 32'h0FE);
            edge1();
        end
        chk("d2_req_last", 32'(imem_req), 32'h1);
        imem_ack = 1'b1;
        edge1();
        chk("d2_pc", 32'(pc), 32'h0FF);
        edge1();
        chk("d2_alu", 32'(alu_en), 32'h1);
        edge1();
        chk("d2_no_we", 32'(rf_we), 32'h0);
        imem_rdata = 16'hF000;
        edge1();
        chk("d2_retired", 32'(retired), 32'h2);
        chk("d3_addr", 32'(imem_addr), 32'h0FF);
        edge1();
        chk("d3_pc_wrap", 32'(pc), 32'h000);
        edge1();
        chk("d3_halted", {30'h0, halted, busy}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk("d3_no_req", 32'(imem_req), 32'h0);
            chk("d3_ret_hold", 32'(retired), 32'h2);
        end

        // Reset during FETCH while an ack arrives on the same edge.
        rst = 1'b1;
        edge1();
        rst = 1'b0; imem_ack = 1'b0;
        edge1();
        chk("d4_in_fetch", 32'(imem_req), 32'h1);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1234;
        edge1();
        chk("d4_ir", 32'(ir), 32'h0);
        chk("d4_pc", 32'(pc), 32'h0FD);
        chk("d4_ret", 32'(retired), 32'h0);
        chk("d4_req", 32'(imem_req), 32'h0);

        // Randomized traffic; the per-cycle comparison does the checking.
        halt_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_mode == M_HALT) halt_cnt++;
            else halt_cnt = 0;
            rst      = (halt_cnt > 3) || ($urandom_range(0, 199) == 0);
            run      = ($urandom_range(0, 7) != 0);
            imem_ack = $urandom_range(0, 1) == 1;
            imem_rdata = 16'($urandom);
            case ($urandom_range(0, 15))
                0:       imem_rdata[15:12] = 4'hF;
                1, 2:    imem_rdata[15:12] = 4'b1001;
                default: if (imem_rdata[15:12] == 4'hF) imem_rdata[15:12] = 4'h3;
            endcase
            edge1();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
